button_debouncer: RTL and testbench



---
 rtl/button_debouncer_if.sv | 22 ++
 rtl/button_debouncer.sv | 120 ++++++++++++
 tb/tb_button_debouncer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - raw button input and debounced status signals
// master drives the raw input; slave is the debouncer.
interface button_debouncer_if;
    logic data_in;
    logic data_out;
    logic busy;
    logic reject;

    modport master (
        output data_in,
        input  data_out,
        input  busy,
        input  reject
    );

    modport slave (
        input  data_in,
        output data_out,
        output busy,
        output reject
    );
endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronise and debounce a bouncy asynchronous input
// data_out flips only after STABLE_CYCLES consecutive samples of the new level.
module button_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    button_debouncer_if.slave  bus
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            data_out_q, data_out_d;
    logic            busy_q, busy_d;
    logic            reject_q, reject_d;

    // Plain shift chain: nothing between stages so each flop gets a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.data_in};
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE_LO;
            cnt_q      <= '0;
            data_out_q <= 1'b0;
            busy_q     <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            reject_q   <= reject_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        reject_d   = 1'b0;

        case (state_q)
            IDLE_LO: begin
                if (sync_q) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!sync_q) begin
                    state_d  = IDLE_LO;
                    cnt_d    = '0;
                    reject_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE_HI;
                    cnt_d      = '0;
                    data_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HI: begin
                if (!sync_q) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (sync_q) begin
                    state_d  = IDLE_HI;
                    cnt_d    = '0;
                    reject_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE_LO;
                    cnt_d      = '0;
                    data_out_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d    = IDLE_LO;
                cnt_d      = '0;
                data_out_d = 1'b0;
            end
        endcase

        busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end

    assign bus.data_out = data_out_q;
    assign bus.busy     = busy_q;
    assign bus.reject   = reject_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer
// Uses SYNC_STAGES=2, STABLE_CYCLES=4 and a 100 ns clock.
module tb_button_debouncer;
    logic clk;
    logic rst_n;

    button_debouncer_if bus ();

    button_debouncer #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic din;
        logic out;
        logic busy;
        logic rej;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int total = 0;
    int bad   = 0;
    int rise_cnt = 0;
    logic prev_out = 1'b0;

    initial clk = 1'b0;
    always #50 clk = ~clk;

    always @(negedge clk) begin
        if (bus.data_out && !prev_out) rise_cnt++;
        prev_out = bus.data_out;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic add(input logic din, input logic out, input logic busy, input logic rej);
        vec_t v;
        v.din = din; v.out = out; v.busy = busy; v.rej = rej;
        vecs.push_back(v);
    endtask

    // Drive one input sample, queue the outputs expected after the next edge, then compare.
    task automatic step(input string tag, input logic din, input logic out,
                        input logic busy, input logic rej);
        vec_t v, e;
        v.din = din; v.out = out; v.busy = busy; v.rej = rej;
        bus.data_in = din;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, " data_out"}, int'(bus.data_out), int'(e.out));
        check({tag, " busy"},     int'(bus.busy),     int'(e.busy));
        check({tag, " reject"},   int'(bus.reject),   int'(e.rej));
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step($sformatf("row%0d", i), vecs[i].din, vecs[i].out, vecs[i].busy, vecs[i].rej);
        end
    endtask

    initial begin
        int seen;
        int rej_cnt;
        int chatter_changes;

        // clean rise: rows 0-6
        add(1,0,0,0); add(1,0,0,0); add(1,0,1,0); add(1,0,1,0);
        add(1,0,1,0); add(1,1,0,0); add(1,1,0,0);
        // bounce reject then clean fall: rows 7-16
        add(0,1,0,0); add(0,1,0,0); add(1,1,1,0); add(0,1,1,0); add(0,1,0,1);
        add(0,1,1,0); add(0,1,1,0); add(0,1,1,0); add(0,0,0,0); add(0,0,0,0);
        // bounce on the last qualifying sample: rows 17-24
        add(1,0,0,0); add(1,0,0,0); add(1,0,1,0); add(0,0,1,0);
        add(0,0,1,0); add(0,0,0,1); add(0,0,0,0); add(0,0,0,0);
        // reject then immediate restart with cnt=1: rows 25-32
        add(1,0,0,0); add(0,0,0,0); add(1,0,1,0); add(1,0,0,1);
        add(1,0,1,0); add(1,0,1,0); add(1,0,1,0); add(1,1,0,0);

        // reset held with data_in=1 while clocking
        rst_n = 1'b0;
        bus.data_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst%0d data_out", i), int'(bus.data_out), 0);
            check($sformatf("rst%0d busy", i),     int'(bus.busy),     0);
            check($sformatf("rst%0d reject", i),   int'(bus.reject),   0);
        end
        bus.data_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        apply_rows(0, 16);
        check("single rise after bounce", rise_cnt, 1);
        apply_rows(17, 32);

        // sub-cycle glitch between edges: data_out must hold
        @(posedge clk);
        #20 bus.data_in = 1'b0;
        #20 bus.data_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("glitch%0d data_out", i), int'(bus.data_out), 1);
        end

        // start a falling qualification, then reset with cnt=2
        step("mq0", 0, 1, 0, 0);
        step("mq1", 0, 1, 0, 0);
        step("mq2", 0, 1, 1, 0);
        step("mq3", 0, 1, 1, 0);
        #30;
        rst_n = 1'b0;
        bus.data_in = 1'b1;
        #1;
        check("async rst data_out", int'(bus.data_out), 0);
        check("async rst busy",     int'(bus.busy),     0);
        check("async rst reject",   int'(bus.reject),   0);
        @(posedge clk);
        #1;
        check("rst edge reject", int'(bus.reject), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        rej_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.reject) rej_cnt++;
            if (bus.data_out && seen == 0) seen = n;
        end
        check("post-reset rise edge", seen, 6);
        check("post-reset rejects", rej_cnt, 0);

        // bring the output low before chatter
        bus.data_in = 1'b0;
        for (int i = 0; i < 10; i++) @(posedge clk);
        #1;
        check("pre-chatter data_out", int'(bus.data_out), 0);

        rej_cnt = 0;
        chatter_changes = 0;
        for (int c = 0; c < 60; c++) begin
            bus.data_in = ((c / 3) % 2 == 0);
            @(posedge clk);
            #1;
            if (bus.data_out !== 1'b0) chatter_changes++;
            if (bus.reject) rej_cnt++;
        end
        check("chatter data_out changes", chatter_changes, 0);
        check("chatter reject pulses", rej_cnt, 10);

        bus.data_in = 1'b1;
        seen = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.data_out && seen == 0) seen = n;
        end
        check("post-chatter rise edge", seen, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
